// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: issues word reads to instruction memory and buffers
// returned words in a 2-entry FIFO. Defining IFETCH_PERF_CNT_EN adds fetch/stall counters.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLk,
    input  logic        RSTn,
    input  logic        fetch_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_tag;
    logic        r_inflight;
    logic        r_squash;

    logic [31:0] r_fifo_inst [2];
    logic [31:0] r_fifo_pc   [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;

    logic        w_pop;
    logic        w_push;
    logic        w_issue;
    logic [2:0]  w_credit;
    logic        w_unused;

    assign w_unused = ^redirect_pc[1:0];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLk or negedge RSTn) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values, independent of block ordering.
        if (!RSTn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so no path leaves the output
        // unassigned, which would otherwise infer a latch.
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (fetch_en)  w_state_next = ST_RUN;
            ST_RUN:  if (!fetch_en) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    // Credit counts buffered words plus the word landing this cycle, minus
    // the word leaving; a new request is safe only if a slot remains for it.
    assign w_credit = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    always_comb begin
        imem_req = 1'b0;
        case (r_state)
            ST_RUN:  imem_req = !redirect_valid && (w_credit < 3'd2);
            default: imem_req = 1'b0;
        endcase
    end

    assign w_issue   = imem_req;
    assign imem_addr = {2'b00, r_pc[31:2]};

    // ------------------------------------------------------------------
    // Program counter and in-flight read tracking
    // ------------------------------------------------------------------
    always_ff @(posedge CLk or negedge RSTn) begin
        if (!RSTn) begin
            r_pc <= RESET_PC_ALIGNED;
        end else if (redirect_valid) begin
            r_pc <= {redirect_pc[31:2], 2'b00};
        end else if (w_issue) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    always_ff @(posedge CLk or negedge RSTn) begin
        if (!RSTn) begin
            r_inflight <= 1'b0;
            r_tag      <= '0;
            r_squash   <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_squash   <= redirect_valid;
            if (w_issue) begin
                r_tag <= r_pc;
            end
        end
    end

    // A returning word is dropped if a redirect is in progress now or
    // happened in the cycle before it landed.
    assign w_push = r_inflight && !r_squash && !redirect_valid;
    assign w_pop  = inst_valid && inst_ready;

    // ------------------------------------------------------------------
    // 2-entry instruction buffer
    // ------------------------------------------------------------------
    always_ff @(posedge CLk or negedge RSTn) begin
        // NOTE: the buffer storage is reset explicitly because inst/inst_pc
        // must read as zero during reset.
        if (!RSTn) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_inst[i] <= '0;
                r_fifo_pc[i]   <= '0;
            end
        end else if (w_push) begin
            r_fifo_inst[r_wr_ptr] <= imem_rdata;
            r_fifo_pc[r_wr_ptr]   <= r_tag;
        end
    end

    always_ff @(posedge CLk or negedge RSTn) begin
        if (!RSTn) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (redirect_valid) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign inst_valid = (r_count != 2'd0);
    assign inst       = r_fifo_inst[r_rd_ptr];
    assign inst_pc    = r_fifo_pc[r_rd_ptr];

`ifdef IFETCH_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters (free-running, wrap at 2^32)
    // ------------------------------------------------------------------
    logic [31:0] r_perf_fetch_cnt;
    logic [31:0] r_perf_stall_cnt;

    always_ff @(posedge CLk or negedge RSTn) begin
        if (!RSTn) begin
            r_perf_fetch_cnt <= '0;
            r_perf_stall_cnt <= '0;
        end else begin
            if (w_push) begin
                r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
            end
            if (inst_valid && !inst_ready) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch_cnt;
    assign perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: cycle table for streaming/stall/redirect,
// a second instance for PC wrap, and a mid-stream reset sequence.
module tb_ifetch_ctrl;

    typedef struct {
        logic        fen;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
    } vec_t;

    logic        CLk = 1'b0;
    logic        RSTn = 1'b1;
    logic        fetch_en = 1'b0;
    logic        inst_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    logic        req1, valid1;
    logic [31:0] addr1, rdata1, inst1, pc1;

    logic        ready2 = 1'b1;
    logic        redirect2 = 1'b0;
    logic [31:0] rpc2 = '0;
    logic        req2, valid2;
    logic [31:0] addr2, rdata2, inst2, pc2;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] pf1, ps1, pf2, ps2;
`endif

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];

    ifetch_ctrl #(.RESET_PC(32'h0000_0000)) dut1 (
        .CLk(CLk), .RSTn(RSTn), .fetch_en(fetch_en),
        .imem_req(req1), .imem_addr(addr1), .imem_rdata(rdata1),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(valid1), .inst_ready(inst_ready), .inst(inst1), .inst_pc(pc1)
`ifdef IFETCH_PERF_CNT_EN
        , .perf_fetch_cnt(pf1), .perf_stall_cnt(ps1)
`endif
    );

    ifetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .CLk(CLk), .RSTn(RSTn), .fetch_en(fetch_en),
        .imem_req(req2), .imem_addr(addr2), .imem_rdata(rdata2),
        .redirect_valid(redirect2), .redirect_pc(rpc2),
        .inst_valid(valid2), .inst_ready(ready2), .inst(inst2), .inst_pc(pc2)
`ifdef IFETCH_PERF_CNT_EN
        , .perf_fetch_cnt(pf2), .perf_stall_cnt(ps2)
`endif
    );

    always #5 CLk = ~CLk;

    // Memory: word[n] = n, valid one cycle after the request; garbage otherwise.
    always @(posedge CLk) rdata1 <= req1 ? addr1 : 32'hDEAD_BEEF;
    always @(posedge CLk) rdata2 <= req2 ? addr2 : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic fen, input logic rdy, input logic rv, input logic [31:0] rpc,
                           input logic req, input logic [31:0] addr, input logic valid,
                           input logic [31:0] inst, input logic [31:0] pc);
        vec_t v;
        v.fen = fen; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.req = req; v.addr = addr; v.valid = valid; v.inst = inst; v.pc = pc;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //       fen rdy rv  rpc            req addr       vld inst       pc
        add_vec(1, 1, 0, 32'h0,         0, 32'h0,      0, 32'h0,      32'h0);   // 0 still IDLE
        add_vec(1, 1, 0, 32'h0,         1, 32'h0,      0, 32'h0,      32'h0);   // 1
        add_vec(1, 1, 0, 32'h0,         1, 32'h1,      0, 32'h0,      32'h0);   // 2
        add_vec(1, 1, 0, 32'h0,         1, 32'h2,      1, 32'h0,      32'h0);   // 3
        add_vec(1, 1, 0, 32'h0,         1, 32'h3,      1, 32'h1,      32'h4);   // 4
        add_vec(1, 1, 0, 32'h0,         1, 32'h4,      1, 32'h2,      32'h8);   // 5
        for (int k = 0; k < 5; k++)
            add_vec(1, 0, 0, 32'h0,     0, 32'h5,      1, 32'h3,      32'hC);   // 6..10 stall
        add_vec(1, 1, 0, 32'h0,         1, 32'h5,      1, 32'h3,      32'hC);   // 11 resume
        add_vec(1, 1, 0, 32'h0,         1, 32'h6,      1, 32'h4,      32'h10);  // 12
        add_vec(1, 1, 0, 32'h0,         1, 32'h7,      1, 32'h5,      32'h14);  // 13
        add_vec(1, 1, 1, 32'h0000_0103, 0, 32'h8,      1, 32'h6,      32'h18);  // 14 redirect
        add_vec(1, 0, 0, 32'h0,         1, 32'h40,     0, 32'h0,      32'h0);   // 15
        add_vec(1, 0, 0, 32'h0,         1, 32'h41,     0, 32'h0,      32'h0);   // 16
        add_vec(1, 0, 0, 32'h0,         0, 32'h42,     1, 32'h40,     32'h100); // 17
        add_vec(1, 1, 0, 32'h0,         1, 32'h42,     1, 32'h40,     32'h100); // 18

        #1 RSTn = 1'b0;
        #1;
        check("rst_req",   {31'b0, req1},   32'h0);
        check("rst_addr",  addr1,           32'h0);
        check("rst_valid", {31'b0, valid1}, 32'h0);
        check("rst_inst",  inst1,           32'h0);
        check("rst_pc",    pc1,             32'h0);
        check("rst_addr2", addr2,           32'h3FFF_FFFE);
`ifdef IFETCH_PERF_CNT_EN
        check("rst_pf",    pf1,             32'h0);
        check("rst_ps",    ps1,             32'h0);
`endif
        repeat (2) @(negedge CLk);
        RSTn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge CLk);
            #1;
            fetch_en       = vecs[i].fen;
            inst_ready     = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            @(negedge CLk);
            check($sformatf("v%0d_req", i),   {31'b0, req1},   {31'b0, vecs[i].req});
            check($sformatf("v%0d_addr", i),  addr1,           vecs[i].addr);
            check($sformatf("v%0d_valid", i), {31'b0, valid1}, {31'b0, vecs[i].valid});
            if (vecs[i].valid) begin
                check($sformatf("v%0d_inst", i), inst1, vecs[i].inst);
                check($sformatf("v%0d_pc", i),   pc1,   vecs[i].pc);
            end
            if (i >= 3 && i <= 5) begin
                logic [31:0] epc;
                epc = 32'hFFFF_FFF8 + 32'(4 * (i - 3));
                check($sformatf("wrap%0d_valid", i), {31'b0, valid2}, 32'h1);
                check($sformatf("wrap%0d_pc", i),    pc2,             epc);
                check($sformatf("wrap%0d_inst", i),  inst2,           epc >> 2);
            end
        end
        redirect_valid = 1'b0;

        // Reset asserted mid-stream with a read in flight.
        @(posedge CLk);
        #3 RSTn = 1'b0;
        #1;
        check("mid_rst_req",   {31'b0, req1},   32'h0);
        check("mid_rst_addr",  addr1,           32'h0);
        check("mid_rst_valid", {31'b0, valid1}, 32'h0);
        check("mid_rst_inst",  inst1,           32'h0);
        check("mid_rst_pc",    pc1,             32'h0);
        check("mid_rst_addr2", addr2,           32'h3FFF_FFFE);
        @(negedge CLk);
        @(posedge CLk);
        @(negedge CLk);
        RSTn = 1'b1;

        // Post-reset: 10 requests, then 3 stall cycles while the buffer drains.
        for (int r = 1; r <= 16; r++) begin
            logic        e_req, e_valid;
            logic [31:0] e_addr, e_pc;
            @(posedge CLk);
            #1;
            fetch_en   = (r < 10);
            inst_ready = !(r >= 11 && r <= 13);
            e_req   = (r <= 10);
            e_addr  = (r <= 10) ? 32'(r - 1) : 32'd10;
            e_valid = (r >= 3 && r <= 15);
            e_pc    = (r <= 10) ? 32'(4 * (r - 3)) : ((r <= 14) ? 32'd32 : 32'd36);
            @(negedge CLk);
            check($sformatf("p%0d_req", r),   {31'b0, req1},   {31'b0, e_req});
            check($sformatf("p%0d_addr", r),  addr1,           e_addr);
            check($sformatf("p%0d_valid", r), {31'b0, valid1}, {31'b0, e_valid});
            if (e_valid) begin
                check($sformatf("p%0d_pc", r),   pc1,   e_pc);
                check($sformatf("p%0d_inst", r), inst1, e_pc >> 2);
            end
        end
`ifdef IFETCH_PERF_CNT_EN
        check("perf_fetch", pf1, 32'd10);
        check("perf_stall", ps1, 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
